// File: rtl/config_loader.sv
// config_loader: collects a serial frame of NUM_INPUTS+1 config words,
// writes it into config_mem through the write_rdy/write_ack handshake,
// then gates the tile on/off. config_mem is never written while on_off=1,
// because the write path and the RUN state are mutually exclusive.
module config_loader #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [WIDTH-1:0]                cfg_data,
    input  logic                            cfg_last,
    input  logic                            start_run,
    input  logic                            stop_run,
    output logic                            mem_write_en,
    input  logic                            mem_write_rdy,
    input  logic                            mem_write_ack,
    output logic [WIDTH*(NUM_INPUTS+1)-1:0] mem_w_data,
    output logic                            mem_on_off,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int unsigned CNT_W   = (NUM_INPUTS > 0) ? $clog2(NUM_INPUTS + 1) : 1;
    localparam int unsigned TMO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned FRAME_W = WIDTH * (NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_WAIT_RDY,
        S_WRITE,
        S_LOADED,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic               we_q, we_d;
    logic               on_q, on_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   word_idx;
    logic               accept;

    // Handshake and status decode straight from the current state
    always_comb begin
        cfg_ready = (state_q == S_COLLECT) | ((state_q == S_LOADED) & ~start_run);
        busy      = (state_q == S_WAIT_RDY) | (state_q == S_WRITE) |
                    ((state_q == S_COLLECT) & (cnt_q != '0));
        accept    = cfg_valid & cfg_ready;
    end

    // Next-state logic: frame collection, write handshake with timeout, run gating
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        data_d   = data_q;
        we_d     = we_q;
        on_d     = on_q;
        done_d   = 1'b0;
        err_d    = err_q;
        // A word accepted in LOADED opens a new frame, so it is word 0
        word_idx = (state_q == S_LOADED) ? '0 : cnt_q;

        case (state_q)
            S_COLLECT, S_LOADED: begin
                if ((state_q == S_LOADED) && start_run && !stop_run) begin
                    state_d = S_RUN;
                    on_d    = 1'b1;
                end else if (accept) begin
                    for (int unsigned i = 0; i <= NUM_INPUTS; i++) begin
                        if (word_idx == CNT_W'(i)) begin
                            data_d[i*WIDTH +: WIDTH] = cfg_data;
                        end
                    end
                    // Clear first so that an error on word 0 itself still sets err
                    if (word_idx == '0) begin
                        err_d = 1'b0;
                    end
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                    if (word_idx == LAST_IDX) begin
                        if (cfg_last) begin
                            state_d = S_WAIT_RDY;
                            tmo_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cfg_last) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = word_idx + CNT_W'(1);
                    end
                end
            end

            S_WAIT_RDY: begin
                if (tmo_q == TMO_LAST) begin
                    state_d = S_COLLECT;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (mem_write_rdy) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                // An ack on the final budgeted cycle still completes the write
                if (mem_write_ack) begin
                    state_d = S_LOADED;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_COLLECT;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_RUN: begin
                if (stop_run) begin
                    state_d = S_LOADED;
                    on_d    = 1'b0;
                end
            end

            default: begin
                state_d = S_COLLECT;
                cnt_d   = '0;
                we_d    = 1'b0;
                on_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; async reset drops the write strobe at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            on_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            we_q    <= we_d;
            on_q    <= on_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_write_en = we_q;
    assign mem_on_off   = on_q;
    assign done         = done_q;
    assign err          = err_q;
    assign mem_w_data   = data_q;

endmodule

// File: tb/tb_config_loader.sv
// Testbench for config_loader: randomized frames and handshake delays checked
// against a frame-level reference model (queue of accepted words, word array,
// cycle-budget arithmetic for the write handshake).
module tb_config_loader;

    localparam int W  = 16;
    localparam int NI = 8;
    localparam int TO = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [W-1:0]       cfg_data;
    logic               cfg_last;
    logic               start_run;
    logic               stop_run;
    logic               mem_write_en;
    logic               mem_write_rdy;
    logic               mem_write_ack;
    logic [W*(NI+1)-1:0] mem_w_data;
    logic               mem_on_off;
    logic               busy;
    logic               done;
    logic               err;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [W-1:0] exp_mem [0:NI];
    logic [W-1:0] fq [$];
    logic         exp_err;

    config_loader #(.WIDTH(W), .NUM_INPUTS(NI), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .start_run(start_run), .stop_run(stop_run),
        .mem_write_en(mem_write_en), .mem_write_rdy(mem_write_rdy), .mem_write_ack(mem_write_ack),
        .mem_w_data(mem_w_data), .mem_on_off(mem_on_off),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W*(NI+1)-1:0] exp_vec();
        logic [W*(NI+1)-1:0] v;
        for (int i = 0; i <= NI; i++) v[i*W +: W] = exp_mem[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i <= NI; i++) exp_mem[i] = '0;
        fq.delete();
        exp_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word in COLLECT/LOADED (start_run low) and update the model
    task automatic send_word(input logic [W-1:0] d, input logic last, output bit complete);
        int idx;
        cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) $display("FAIL word_ready: got %b want 1", cfg_ready); else passes++;
        complete = 1'b0;
        idx = fq.size();
        exp_mem[idx] = d;
        if (idx == 0) exp_err = 1'b0;
        fq.push_back(d);
        if (last && idx == NI) begin
            complete = 1'b1;
            fq.delete();
        end else if (last || idx == NI) begin
            exp_err = 1'b1;
            fq.delete();
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0; cfg_last = 1'b0;
        checks++;
        if (err !== exp_err) $display("FAIL word_err: got %b want %b (idx %0d)", err, exp_err, idx); else passes++;
        checks++;
        if (busy !== (fq.size() != 0 || complete))
            $display("FAIL word_busy: got %b want %b (idx %0d)", busy, (fq.size() != 0 || complete), idx);
        else passes++;
    endtask

    task automatic send_random_frame(input int n, input int last_at, output bit complete);
        bit c;
        complete = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_word(W'($urandom), (i == last_at), c);
            if (c) complete = 1'b1;
        end
    endtask

    // Drive the write handshake: rdy rises rdy_dly cycles into WAIT_RDY,
    // ack rises ack_dly cycles after write_en is first seen.
    task automatic run_write(input int rdy_dly, input int ack_dly);
        int  total, done_c, err_c, we_cnt, we_start, bad_data, exp_we;
        bit  ok;
        total = rdy_dly + ack_dly + 2;
        ok = (total <= TO);
        done_c = -1; err_c = -1; we_cnt = 0; we_start = -1; bad_data = 0;
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || mem_write_en !== 1'b0)
            $display("FAIL wait_rdy_entry: busy=%b ready=%b we=%b want 1 0 0", busy, cfg_ready, mem_write_en);
        else passes++;
        for (int c = 0; c < TO + 10; c++) begin
            if (done === 1'b1) begin done_c = c; break; end
            if (err === 1'b1) begin err_c = c; break; end
            if (mem_write_en === 1'b1) begin
                we_cnt++;
                if (we_start < 0) we_start = c;
                if (mem_w_data !== exp_vec()) bad_data++;
            end
            mem_write_rdy = (c >= rdy_dly);
            mem_write_ack = (we_start >= 0) && (c - we_start >= ack_dly);
            tick();
        end
        mem_write_rdy = 1'b0; mem_write_ack = 1'b0;
        checks++;
        if (bad_data != 0) $display("FAIL write_data_stable: %0d cycles differed, want 0", bad_data); else passes++;
        if (ok) begin
            checks++;
            if (done_c != total) $display("FAIL done_latency: got cycle %0d want %0d", done_c, total); else passes++;
            checks++;
            if (we_cnt != ack_dly + 1) $display("FAIL we_cycles: got %0d want %0d", we_cnt, ack_dly + 1); else passes++;
            checks++;
            if (mem_write_en !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0 || err !== exp_err)
                $display("FAIL loaded_state: we=%b ready=%b busy=%b err=%b want 0 1 0 %b",
                         mem_write_en, cfg_ready, busy, err, exp_err);
            else passes++;
            tick();
            checks++;
            if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done); else passes++;
        end else begin
            exp_err = 1'b1;
            exp_we = (TO - 1 - rdy_dly > 0) ? TO - 1 - rdy_dly : 0;
            checks++;
            if (err_c != TO || done_c != -1)
                $display("FAIL timeout_cycle: err at %0d done at %0d want %0d -1", err_c, done_c, TO);
            else passes++;
            checks++;
            if (we_cnt != exp_we) $display("FAIL timeout_we_cycles: got %0d want %0d", we_cnt, exp_we); else passes++;
            checks++;
            if (cfg_ready !== 1'b1 || mem_write_en !== 1'b0 || busy !== 1'b0)
                $display("FAIL timeout_state: ready=%b we=%b busy=%b want 1 0 0", cfg_ready, mem_write_en, busy);
            else passes++;
        end
        checks++;
        if (mem_w_data !== exp_vec()) $display("FAIL write_mem_data: got %h want %h", mem_w_data, exp_vec()); else passes++;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (cfg_ready !== 1'b1 || mem_write_en !== 1'b0 || mem_on_off !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || mem_w_data !== '0)
            $display("FAIL %s: ready=%b we=%b on=%b busy=%b done=%b err=%b data=%h want 1 0 0 0 0 0 0",
                     tag, cfg_ready, mem_write_en, mem_on_off, busy, done, err, mem_w_data);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 0; cfg_data = '0; cfg_last = 0; start_run = 0; stop_run = 0;
        mem_write_rdy = 0; mem_write_ack = 0;
        model_clear();
        repeat (3) tick();
        check_reset_outputs("reset_held");
        reset = 1'b0;
        tick();
        check_reset_outputs("reset_released");
    endtask

    task automatic test_full_frame();
        bit c;
        for (int i = 0; i <= NI; i++) send_word(W'(16'h1111 * (i + 1)), (i == NI), c);
        checks++;
        if (c !== 1'b1) $display("FAIL frame_complete: got %b want 1", c); else passes++;
        run_write(0, 1);
        checks++;
        if (mem_w_data[0 +: W] !== 16'h1111 || mem_w_data[NI*W +: W] !== 16'h9999)
            $display("FAIL frame_words: w0=%h w8=%h want 1111 9999", mem_w_data[0 +: W], mem_w_data[NI*W +: W]);
        else passes++;
    endtask

    task automatic test_min_latency();
        bit c;
        send_random_frame(NI + 1, NI, c);
        run_write(0, 0);
    endtask

    task automatic test_early_last();
        bit c;
        send_random_frame(4, 3, c);
        checks++;
        if (err !== 1'b1 || mem_write_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1)
            $display("FAIL early_last: err=%b we=%b busy=%b ready=%b want 1 0 0 1", err, mem_write_en, busy, cfg_ready);
        else passes++;
        send_random_frame(NI + 1, -1, c);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) $display("FAIL no_last: err=%b busy=%b want 1 0", err, busy); else passes++;
        send_random_frame(NI + 1, NI, c);
        run_write($urandom_range(0, 4), $urandom_range(0, 4));
    endtask

    task automatic test_timeout();
        bit c;
        send_random_frame(NI + 1, NI, c);
        run_write(TO + 5, 0);
        send_random_frame(NI + 1, NI, c);
        run_write(5, TO - 7);
        send_random_frame(NI + 1, NI, c);
        run_write(5, TO - 6);
        send_random_frame(NI + 1, NI, c);
        run_write(TO - 2, 0);
    endtask

    task automatic test_run();
        logic [W*(NI+1)-1:0] hold;
        hold = exp_vec();
        start_run = 1'b1; cfg_valid = 1'b1; cfg_data = W'($urandom);
        #1;
        checks++;
        if (cfg_ready !== 1'b0) $display("FAIL run_start_ready: got %b want 0", cfg_ready); else passes++;
        tick();
        start_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_data = W'($urandom);
            #1;
            checks++;
            if (mem_on_off !== 1'b1 || cfg_ready !== 1'b0 || mem_write_en !== 1'b0 || busy !== 1'b0)
                $display("FAIL run_state: on=%b ready=%b we=%b busy=%b want 1 0 0 0", mem_on_off, cfg_ready, mem_write_en, busy);
            else passes++;
            tick();
        end
        cfg_valid = 1'b0;
        checks++;
        if (mem_w_data !== hold) $display("FAIL run_no_accept: got %h want %h", mem_w_data, hold); else passes++;
        start_run = 1'b1; stop_run = 1'b1;
        tick();
        start_run = 1'b0; stop_run = 1'b0;
        #1;
        checks++;
        if (mem_on_off !== 1'b0 || cfg_ready !== 1'b1) $display("FAIL run_stop: on=%b ready=%b want 0 1", mem_on_off, cfg_ready);
        else passes++;
    endtask

    task automatic test_start_stop_loaded();
        logic [W*(NI+1)-1:0] hold;
        hold = exp_vec();
        start_run = 1'b1; stop_run = 1'b1; cfg_valid = 1'b1; cfg_data = W'($urandom);
        repeat (2) tick();
        checks++;
        if (mem_on_off !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b0 || mem_w_data !== hold)
            $display("FAIL loaded_both: on=%b ready=%b busy=%b data=%h want 0 0 0 %h", mem_on_off, cfg_ready, busy, mem_w_data, hold);
        else passes++;
        stop_run = 1'b0;
        tick();
        start_run = 1'b0; cfg_valid = 1'b0;
        #1;
        checks++;
        if (mem_on_off !== 1'b1 || mem_w_data !== hold)
            $display("FAIL loaded_start_priority: on=%b data=%h want 1 %h", mem_on_off, mem_w_data, hold);
        else passes++;
        stop_run = 1'b1;
        tick();
        stop_run = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        bit c;
        bit seen;
        send_random_frame(NI + 1, NI, c);
        mem_write_rdy = 1'b1; mem_write_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mem_write_en === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) $display("FAIL reset_write_seen: write_en %b want 1 within 5 cycles", mem_write_en); else passes++;
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid_write");
        @(posedge clk);
        #1;
        reset = 1'b0; mem_write_rdy = 1'b0;
        model_clear();
        tick();
        send_random_frame(NI + 1, NI, c);
        run_write(1, 0);
    endtask

    task automatic test_back_to_back();
        bit c;
        int kind;
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    int n;
                    n = $urandom_range(1, NI);
                    send_random_frame(n, n - 1, c);
                end
                1: send_random_frame(NI + 1, -1, c);
                default: begin
                    send_random_frame(NI + 1, NI, c);
                    run_write($urandom_range(0, 8), $urandom_range(0, 8));
                end
            endcase
            checks++;
            if (mem_w_data !== exp_vec() || err !== exp_err)
                $display("FAIL b2b_iter%0d: data=%h err=%b want %h %b", it, mem_w_data, err, exp_vec(), exp_err);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_run();
        test_start_stop_loaded();
        test_min_latency();
        test_early_last();
        test_timeout();
        test_reset_mid_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
